// File: rtl/line_shift_ram_multi_if.sv
// line_shift_ram_multi_if
//   Bundles the raster-stream inputs and the aligned tap outputs of the
//   multi-line shift buffer.
//   Ports (master = stream source / consumer, slave = line buffer):
//     clken, per_frame_vsync, per_frame_href, shiftin   : source -> buffer
//     dout_cur, taps, taps_valid, dout_en,
//     line_len, line_overflow                           : buffer -> consumer
//   Handshake: there is no back-pressure. A pixel is taken on every clock
//   where clken & per_frame_href is high. Exactly one cycle later dout_en
//   pulses for one cycle and dout_cur/taps/taps_valid carry that pixel's
//   column. Between pulses the data outputs hold their last value.
interface line_shift_ram_multi_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_TAPS = 2,
  parameter int ADDR_W   = 11
);
  logic                       clken;
  logic                       per_frame_vsync;
  logic                       per_frame_href;
  logic [DATA_W-1:0]          shiftin;
  logic [DATA_W-1:0]          dout_cur;
  logic [NUM_TAPS*DATA_W-1:0] taps;
  logic [NUM_TAPS-1:0]        taps_valid;
  logic                       dout_en;
  logic [ADDR_W:0]            line_len;
  logic                       line_overflow;

  modport master (
    output clken, per_frame_vsync, per_frame_href, shiftin,
    input  dout_cur, taps, taps_valid, dout_en, line_len, line_overflow
  );

  modport slave (
    input  clken, per_frame_vsync, per_frame_href, shiftin,
    output dout_cur, taps, taps_valid, dout_en, line_len, line_overflow
  );
endinterface

// File: rtl/line_shift_ram_multi.sv
// line_shift_ram_multi
//   N-line video line buffer. Keeps the last NUM_TAPS lines of a raster
//   stream and, for every accepted pixel, presents the same column from the
//   NUM_TAPS lines above it, one cycle later and cycle-aligned with the pixel.
//   Tracks how many lines of the current frame have been filled so window
//   filters can zero-pad the top border (ZERO_INVALID=1).
//   Ports:
//     clock  : sole clock, all logic on posedge
//     rst    : synchronous active-high reset
//     bus    : line_shift_ram_multi_if slave (stream in, taps out)
module line_shift_ram_multi #(
  parameter int DATA_W       = 8,
  parameter int NUM_TAPS     = 2,
  parameter int ADDR_W       = 11,
  parameter int ZERO_INVALID = 1
) (
  input  logic                  clock,
  input  logic                  rst,
  line_shift_ram_multi_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int FILL_W = 4;  // holds 0..8 lines
  localparam logic [ADDR_W:0] LAST_COL = (ADDR_W+1)'(DEPTH - 1);

  // One extra column bit: col == DEPTH marks an overflowed line, where the
  // column is held and nothing more is written.
  logic [ADDR_W:0]            col;
  logic [FILL_W-1:0]          lines_filled;
  logic                       href_q;
  logic                       vsync_q;

  logic [DATA_W-1:0]          dout_cur_q;
  logic [NUM_TAPS*DATA_W-1:0] taps_q;
  logic [NUM_TAPS-1:0]        taps_valid_q;
  logic                       dout_en_q;
  logic [ADDR_W:0]            line_len_q;
  logic                       line_overflow_q;

  logic                       acc;
  logic                       wr_en;
  logic                       col_full;
  logic                       href_rise;
  logic                       href_fall;
  logic                       vsync_rise;
  logic [ADDR_W-1:0]          addr;

  logic [DATA_W-1:0]          ram [NUM_TAPS][DEPTH];
  logic [DATA_W-1:0]          rd_data [NUM_TAPS];
  logic [DATA_W-1:0]          tap_next [NUM_TAPS];
  logic [NUM_TAPS-1:0]        valid_next;

  assign acc        = bus.clken & bus.per_frame_href & ~rst;
  assign col_full   = col[ADDR_W];
  assign wr_en      = acc & ~col_full;
  assign addr       = col[ADDR_W-1:0];
  assign href_rise  = bus.per_frame_href & ~href_q;
  assign href_fall  = ~bus.per_frame_href & href_q;
  assign vsync_rise = bus.per_frame_vsync & ~vsync_q;

  // Line cascade: each RAM shifts its column one line deeper. Reads are
  // asynchronous and the writes are non-blocking, so every read in this
  // cycle sees the pre-write contents of the same column.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      ram[0][addr] <= bus.shiftin;
      for (int k = 1; k < NUM_TAPS; k++) begin
        ram[k][addr] <= ram[k-1][addr];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      rd_data[k]    = ram[k][addr];
      valid_next[k] = int'(lines_filled) > k;
      tap_next[k]   = rd_data[k];
      if (col_full) begin
        tap_next[k] = '0;
      end else if ((ZERO_INVALID != 0) && !valid_next[k]) begin
        tap_next[k] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      col             <= '0;
      lines_filled    <= '0;
      href_q          <= 1'b0;
      vsync_q         <= 1'b0;
      dout_cur_q      <= '0;
      taps_q          <= '0;
      taps_valid_q    <= '0;
      dout_en_q       <= 1'b0;
      line_len_q      <= '0;
      line_overflow_q <= 1'b0;
    end else begin
      href_q    <= bus.per_frame_href;
      vsync_q   <= bus.per_frame_vsync;
      dout_en_q <= acc;

      if (acc) begin
        dout_cur_q   <= bus.shiftin;
        taps_valid_q <= valid_next;
        for (int k = 0; k < NUM_TAPS; k++) begin
          taps_q[k*DATA_W +: DATA_W] <= tap_next[k];
        end
      end

      if (vsync_rise || !bus.per_frame_href) begin
        col <= '0;
      end else if (acc && !col_full) begin
        col <= col + 1'b1;
      end

      // A completed line still reports its length when vsync rises on the
      // same cycle; only the fill count is overridden by the frame start.
      if (href_fall && (col != '0)) begin
        line_len_q <= col;
      end

      if (vsync_rise) begin
        lines_filled <= '0;
      end else if (href_fall && (col != '0) && (int'(lines_filled) < NUM_TAPS)) begin
        lines_filled <= lines_filled + 1'b1;
      end

      if (href_rise) begin
        line_overflow_q <= 1'b0;
      end else if (acc && (col == LAST_COL)) begin
        line_overflow_q <= 1'b1;
      end
    end
  end

  assign bus.dout_cur      = dout_cur_q;
  assign bus.taps          = taps_q;
  assign bus.taps_valid    = taps_valid_q;
  assign bus.dout_en       = dout_en_q;
  assign bus.line_len      = line_len_q;
  assign bus.line_overflow = line_overflow_q;
endmodule
